// File: rtl/pe_operand_buffer_pkg.sv
// Shared lane-count, mask and default-width definitions for the PE operand buffer.
package pe_operand_buffer_pkg;

  localparam int unsigned NUM_LANES  = 4;
  localparam int unsigned OPMASK_W   = NUM_LANES;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 2;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef logic [OPMASK_W-1:0] lane_mask_t;

  // Occupancy counter width able to hold 0..depth inclusive.
  function automatic int unsigned lane_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pe_operand_buffer_lane_fifo.sv
// Single operand lane: DEPTH-entry FIFO with occupancy count and synchronous flush.
module pe_operand_buffer_lane_fifo
  import pe_operand_buffer_pkg::*;
#(
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned DEPTH  = DEPTH_DEF,
  localparam int unsigned CNT_LW = lane_cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] head_o,
  output logic [CNT_LW-1:0] count_o,
  output logic              full_o
);

  localparam int unsigned PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_LW-1:0] cnt_q, cnt_d;
  logic              push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Guards keep the count inside 0..DEPTH even if the caller misbehaves.
  assign full_o  = (cnt_q == CNT_LW'(DEPTH));
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && (cnt_q != '0) && !flush_i;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + CNT_LW'(1);
        2'b01:   cnt_d = cnt_q - CNT_LW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; entries are only observed through a non-zero count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/pe_operand_buffer.sv
// Per-lane operand FIFOs feeding the ALU; gathers a complete masked operand set and counts fires.
module pe_operand_buffer
  import pe_operand_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    in_R0,
  input  logic [DATA_W-1:0]    in_R1,
  input  logic [DATA_W-1:0]    in_R2,
  input  logic [DATA_W-1:0]    in_R3,
  input  lane_mask_t           in_valid,
  output lane_mask_t           in_ready,
  input  lane_mask_t           use_mask,
  input  logic                 flush,
  output logic [DATA_W-1:0]    op0,
  output logic [DATA_W-1:0]    op1,
  output logic [DATA_W-1:0]    op2,
  output logic [DATA_W-1:0]    op3,
  output logic                 op_valid,
  input  logic                 op_ready,
  output logic [CNT_W-1:0]     fire_cnt
);

  localparam int unsigned LCNT_W = lane_cnt_w(DEPTH);

  logic [DATA_W-1:0] din  [NUM_LANES];
  logic [DATA_W-1:0] head [NUM_LANES];
  logic [DATA_W-1:0] op   [NUM_LANES];
  logic [LCNT_W-1:0] cnt  [NUM_LANES];
  lane_mask_t        full, push, pop, lane_has;
  logic              rdy_en_q, fire;
  logic [CNT_W-1:0]  fire_cnt_q, fire_cnt_d;

  assign din[0] = in_R0;
  assign din[1] = in_R1;
  assign din[2] = in_R2;
  assign din[3] = in_R3;

  // Holds in_ready low during reset and for the first cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en_q <= 1'b0;
    else        rdy_en_q <= 1'b1;
  end

  assign in_ready = {NUM_LANES{rdy_en_q && !flush}} & ~full;
  assign push     = in_valid & in_ready;
  assign op_valid = (use_mask != '0) && ((lane_has & use_mask) == use_mask);
  assign fire     = op_valid && op_ready;
  assign pop      = {NUM_LANES{fire}} & use_mask;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    pe_operand_buffer_lane_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .din_i   (din[i]),
      .head_o  (head[i]),
      .count_o (cnt[i]),
      .full_o  (full[i])
    );
    assign lane_has[i] = (cnt[i] != '0);
    assign op[i]       = (use_mask[i] && lane_has[i]) ? head[i] : '0;
  end

  assign op0 = op[0];
  assign op1 = op[1];
  assign op2 = op[2];
  assign op3 = op[3];

  always_comb begin
    fire_cnt_d = fire_cnt_q;
    if (flush)     fire_cnt_d = '0;
    else if (fire) fire_cnt_d = fire_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fire_cnt_q <= '0;
    else        fire_cnt_q <= fire_cnt_d;
  end

  assign fire_cnt = fire_cnt_q;

endmodule

// File: tb/tb_pe_operand_buffer.sv
// Directed vector table plus randomized traffic against a queue-based operand buffer model.
module tb_pe_operand_buffer;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = 4;
  localparam int          NV    = 25;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [DW-1:0] d_r0, d_r1, d_r2, d_r3;
  logic [3:0]    in_valid, in_ready, use_mask;
  logic          flush, op_valid, op_ready;
  logic [DW-1:0] op0, op1, op2, op3;
  logic [CW-1:0] fire_cnt;

  pe_operand_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_R0    (d_r0),
    .in_R1    (d_r1),
    .in_R2    (d_r2),
    .in_R3    (d_r3),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .use_mask (use_mask),
    .flush    (flush),
    .op0      (op0),
    .op1      (op1),
    .op2      (op2),
    .op3      (op3),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .fire_cnt (fire_cnt)
  );

  typedef struct packed {
    logic [3:0]  iv;
    logic [3:0]  m;
    logic        fl;
    logic        ordy;
    logic [31:0] d0, d1, d2, d3;
    logic [3:0]  e_rdy;
    logic        e_val;
    logic [31:0] e0, e1, e2, e3;
    logic [3:0]  e_fc;
  } vec_t;

  vec_t tv [NV];

  // Reference model: one queue per lane, plain modulo fire counter.
  logic [31:0] mq [4][$];
  int          m_fc;
  bit          m_rdy, last_fire;
  logic [3:0]  m_ready;
  logic        m_valid;
  logic [31:0] m_op [4];

  int n_chk, n_err, cyc_no;

  function automatic vec_t mk(input logic [3:0] iv, input logic [3:0] m, input logic fl,
                              input logic ordy, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input logic [3:0] erdy, input logic ev, input logic [31:0] e0,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic [31:0] e3, input logic [3:0] efc);
    vec_t v;
    v.iv = iv; v.m = m; v.fl = fl; v.ordy = ordy;
    v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3;
    v.e_rdy = erdy; v.e_val = ev;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3; v.e_fc = efc;
    return v;
  endfunction

  function automatic logic [31:0] rin(input int i);
    case (i)
      0:       return d_r0;
      1:       return d_r1;
      2:       return d_r2;
      default: return d_r3;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: actual=0x%0h required=0x%0h", nm, cyc_no, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] erdy, input logic ev,
                           input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                           input logic [31:0] e3, input logic [3:0] efc);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(erdy));
    chk({tag, ".op_valid"}, 32'(op_valid), 32'(ev));
    chk({tag, ".op0"}, op0, e0);
    chk({tag, ".op1"}, op1, e1);
    chk({tag, ".op2"}, op2, e2);
    chk({tag, ".op3"}, op3, e3);
    chk({tag, ".fire_cnt"}, 32'(fire_cnt), 32'(efc));
  endtask

  task automatic model_eval();
    m_valid = (use_mask != 4'b0000);
    for (int i = 0; i < 4; i++) begin
      m_ready[i] = m_rdy && !flush && (mq[i].size() < DEPTH);
      if (use_mask[i] && mq[i].size() == 0) m_valid = 1'b0;
      m_op[i] = (use_mask[i] && mq[i].size() != 0) ? mq[i][0] : 32'h0;
    end
  endtask

  task automatic model_edge();
    last_fire = 1'b0;
    if (flush) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      m_fc = 0;
    end else begin
      last_fire = m_valid && op_ready;
      for (int i = 0; i < 4; i++)
        if (last_fire && use_mask[i]) void'(mq[i].pop_front());
      for (int i = 0; i < 4; i++)
        if (in_valid[i] && m_ready[i]) mq[i].push_back(rin(i));
      if (last_fire) m_fc = (m_fc + 1) % (1 << CW);
    end
    m_rdy = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mq[i].delete();
    m_fc = 0;
    m_rdy = 1'b0;
    last_fire = 1'b0;
  endtask

  // One clock cycle checked against the model; called at a falling edge.
  task automatic cyc(input logic [3:0] iv, input logic [3:0] m, input logic fl,
                     input logic ordy, input string tag);
    in_valid = iv; use_mask = m; flush = fl; op_ready = ordy;
    d_r0 = $urandom; d_r1 = $urandom; d_r2 = $urandom; d_r3 = $urandom;
    #1;
    model_eval();
    check_all(tag, m_ready, m_valid, m_op[0], m_op[1], m_op[2], m_op[3], 4'(m_fc));
    @(posedge clk);
    model_edge();
    cyc_no++;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] cur_mask;
    int         guard;
    n_chk = 0; n_err = 0; cyc_no = 0;
    rst_n = 1'b0; in_valid = '0; use_mask = '0; flush = 1'b0; op_ready = 1'b0;
    d_r0 = '0; d_r1 = '0; d_r2 = '0; d_r3 = '0;
    model_reset();

    tv[0]  = mk(4'h0, 4'h3, 0, 0, 0, 0, 0, 0,                       4'h0, 0, 0, 0, 0, 0, 4'd0);
    tv[1]  = mk(4'h3, 4'h3, 0, 1, 32'h11, 32'h22, 0, 0,             4'hF, 0, 0, 0, 0, 0, 4'd0);
    tv[2]  = mk(4'h0, 4'h3, 0, 1, 0, 0, 0, 0,                       4'hF, 1, 32'h11, 32'h22, 0, 0, 4'd0);
    tv[3]  = mk(4'h1, 4'h5, 0, 1, 32'hA5, 0, 0, 0,                  4'hF, 0, 0, 0, 0, 0, 4'd1);
    tv[4]  = mk(4'h0, 4'h5, 0, 1, 0, 0, 0, 0,                       4'hF, 0, 32'hA5, 0, 0, 0, 4'd1);
    tv[5]  = mk(4'h4, 4'h5, 0, 0, 0, 0, 32'h5A, 0,                  4'hF, 0, 32'hA5, 0, 0, 0, 4'd1);
    tv[6]  = mk(4'h0, 4'h5, 0, 0, 0, 0, 0, 0,                       4'hF, 1, 32'hA5, 0, 32'h5A, 0, 4'd1);
    tv[7]  = mk(4'h0, 4'h5, 0, 1, 0, 0, 0, 0,                       4'hF, 1, 32'hA5, 0, 32'h5A, 0, 4'd1);
    tv[8]  = mk(4'h8, 4'h8, 0, 0, 0, 0, 0, 32'd1,                   4'hF, 0, 0, 0, 0, 0, 4'd2);
    tv[9]  = mk(4'h8, 4'h8, 0, 0, 0, 0, 0, 32'd2,                   4'hF, 1, 0, 0, 0, 32'd1, 4'd2);
    tv[10] = mk(4'h8, 4'h8, 0, 0, 0, 0, 0, 32'd3,                   4'h7, 1, 0, 0, 0, 32'd1, 4'd2);
    tv[11] = mk(4'h0, 4'h8, 0, 1, 0, 0, 0, 0,                       4'h7, 1, 0, 0, 0, 32'd1, 4'd2);
    tv[12] = mk(4'h0, 4'h8, 0, 0, 0, 0, 0, 0,                       4'hF, 1, 0, 0, 0, 32'd2, 4'd3);
    tv[13] = mk(4'h0, 4'h8, 0, 1, 0, 0, 0, 0,                       4'hF, 1, 0, 0, 0, 32'd2, 4'd3);
    tv[14] = mk(4'h1, 4'h1, 0, 0, 32'h10, 0, 0, 0,                  4'hF, 0, 0, 0, 0, 0, 4'd4);
    tv[15] = mk(4'h1, 4'h1, 0, 0, 32'h20, 0, 0, 0,                  4'hF, 1, 32'h10, 0, 0, 0, 4'd4);
    tv[16] = mk(4'h1, 4'h1, 0, 1, 32'h30, 0, 0, 0,                  4'hE, 1, 32'h10, 0, 0, 0, 4'd4);
    tv[17] = mk(4'h0, 4'h1, 0, 0, 0, 0, 0, 0,                       4'hF, 1, 32'h20, 0, 0, 0, 4'd5);
    tv[18] = mk(4'h1, 4'h1, 0, 1, 32'h40, 0, 0, 0,                  4'hF, 1, 32'h20, 0, 0, 0, 4'd5);
    tv[19] = mk(4'h0, 4'h1, 0, 0, 0, 0, 0, 0,                       4'hF, 1, 32'h40, 0, 0, 0, 4'd6);
    tv[20] = mk(4'hF, 4'hF, 0, 0, 32'hB0, 32'hB1, 32'hB2, 32'hB3,   4'hF, 0, 32'h40, 0, 0, 0, 4'd6);
    tv[21] = mk(4'hF, 4'hF, 1, 1, 32'hC0, 32'hC1, 32'hC2, 32'hC3,   4'h0, 1, 32'h40, 32'hB1, 32'hB2, 32'hB3, 4'd6);
    tv[22] = mk(4'h0, 4'hF, 0, 1, 0, 0, 0, 0,                       4'hF, 0, 0, 0, 0, 0, 4'd0);
    tv[23] = mk(4'h1, 4'h1, 0, 0, 32'hD0, 0, 0, 0,                  4'hF, 0, 0, 0, 0, 0, 4'd0);
    tv[24] = mk(4'h0, 4'h1, 0, 1, 0, 0, 0, 0,                       4'hF, 1, 32'hD0, 0, 0, 0, 4'd0);

    repeat (3) @(negedge clk);
    use_mask = 4'h3;
    #1;
    check_all("reset", 4'h0, 1'b0, 0, 0, 0, 0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < NV; k++) begin
      in_valid = tv[k].iv; use_mask = tv[k].m; flush = tv[k].fl; op_ready = tv[k].ordy;
      d_r0 = tv[k].d0; d_r1 = tv[k].d1; d_r2 = tv[k].d2; d_r3 = tv[k].d3;
      #1;
      model_eval();
      check_all($sformatf("vec%0d", k), tv[k].e_rdy, tv[k].e_val,
                tv[k].e0, tv[k].e1, tv[k].e2, tv[k].e3, tv[k].e_fc);
      @(posedge clk);
      model_edge();
      cyc_no++;
      @(negedge clk);
    end

    // Random traffic; the mask only moves when no set is pending or right after a fire.
    cur_mask = 4'b0011;
    for (int k = 0; k < 400; k++) begin
      bit fl;
      use_mask = cur_mask; flush = 1'b0;
      model_eval();
      if (!m_valid || last_fire) cur_mask = 4'($urandom_range(0, 15));
      fl = ($urandom_range(0, 31) == 0);
      cyc(4'($urandom_range(0, 15)), cur_mask, fl, 1'($urandom_range(0, 1)), "rand");
    end

    cyc(4'h0, 4'h1, 1'b1, 1'b0, "wrap_flush");
    guard = 0;
    while (m_fc != 14 && guard < 64) begin
      cyc(4'h1, 4'h1, 1'b0, 1'b1, "wrap_pre");
      guard++;
    end
    chk("wrap_preload", 32'(fire_cnt), 32'd14);
    repeat (16) cyc(4'h1, 4'h1, 1'b0, 1'b1, "wrap_burst");
    chk("wrap_return", 32'(fire_cnt), 32'd14);

    in_valid = 4'h1; use_mask = 4'h1; flush = 1'b0; op_ready = 1'b1;
    #1;
    chk("pre_rst_op_valid", 32'(op_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 4'h0, 1'b0, 0, 0, 0, 0, 4'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(4'h0, 4'hF, 1'b0, 1'b1, "post_rst0");
    cyc(4'h0, 4'hF, 1'b0, 1'b1, "post_rst1");
    cyc(4'h3, 4'h3, 1'b0, 1'b0, "post_rst2");
    cyc(4'h0, 4'h3, 1'b0, 1'b1, "post_rst3");
    cyc(4'h0, 4'h3, 1'b0, 1'b1, "post_rst4");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
